// File: rtl/mod_arith_pkg.sv
// Shared constants and FSM encoding for the modular-exponentiation sequencer.
package mod_arith_pkg;

  localparam int MOD_WIDTH = 128;

  localparam logic [MOD_WIDTH-1:0] ONE = MOD_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL_REQ,
    MUL_WAIT,
    SQR_REQ,
    SQR_WAIT,
    DONE
  } mexp_state_e;

endpackage

// File: rtl/mod_exp_sequencer.sv
// Right-to-left square-and-multiply base^exp mod mod, driving one shared
// external modular multiplier through a start/done handshake.
module mod_exp_sequencer
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] mod,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0] mul_mod,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_result
);

  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  mexp_state_e      state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sq_q, sq_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             e_last;

  // The current exponent bit is the last one set: skip the trailing square.
  assign e_last = ((e_q >> 1) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sq_q    <= '0;
      e_q     <= '0;
      m_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      e_q     <= e_d;
      m_q     <= m_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    e_d     = e_q;
    m_d     = m_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = WIDTH'(ONE);
          sq_d    = base;
          e_d     = exp;
          m_d     = mod;
          err_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (m_q < TWO) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = DONE;
        end else if (e_q == '0) begin
          res_d   = acc_q;
          state_d = DONE;
        end else if (e_q[0]) begin
          a_d     = acc_q;
          b_d     = sq_q;
          state_d = MUL_REQ;
        end else begin
          a_d     = sq_q;
          b_d     = sq_q;
          state_d = SQR_REQ;
        end
      end
      MUL_REQ: state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (mul_done) begin
          acc_d = mul_result;
          if (e_last) begin
            e_d     = '0;
            state_d = CHECK;
          end else begin
            a_d     = sq_q;
            b_d     = sq_q;
            state_d = SQR_REQ;
          end
        end
      end
      SQR_REQ: state_d = SQR_WAIT;
      SQR_WAIT: begin
        if (mul_done) begin
          sq_d    = mul_result;
          e_d     = e_q >> 1;
          state_d = CHECK;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are loaded on entry to *_REQ and only change after the matching
  // mul_done, so they stay stable across the whole request.
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign mul_mod   = m_q;
  assign mul_start = (state_q == MUL_REQ) || (state_q == SQR_REQ);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign error     = err_q;
  assign result    = res_q;

endmodule

// File: tb/tb_mod_exp_sequencer.sv
// Directed + randomised bench for mod_exp_sequencer with a random-latency multiplier model.
module tb_mod_exp_sequencer;
  localparam int W     = 128;
  localparam int LIMIT = 20000;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] base, exp, mod;
  logic         busy, done, error, mul_start, mul_done;
  logic [W-1:0] result, mul_a, mul_b, mul_mod, mul_result;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_bad = 0;

  always #5 clk = ~clk;

  mod_exp_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp), .mod(mod),
    .busy(busy), .done(done), .error(error), .result(result),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_mod(mul_mod),
    .mul_done(mul_done), .mul_result(mul_result)
  );

  // Multiplier model: random 1..20 cycle latency, one request at a time.
  logic         md_q, pending, stray, stray_en;
  int           cnt;
  logic [W-1:0] mres, cap_a, cap_b, cap_m, junk;

  always @(posedge clk) begin
    if (rst) begin
      md_q    <= 1'b0;
      pending <= 1'b0;
      cnt     <= 0;
      mres    <= '0;
    end else begin
      md_q <= 1'b0;
      if (pending) begin
        if (cnt <= 1) begin
          md_q    <= 1'b1;
          pending <= 1'b0;
        end else cnt <= cnt - 1;
      end
      if (mul_start) begin
        pending <= 1'b1;
        cnt     <= $urandom_range(1, 20);
        cap_a   <= mul_a;
        cap_b   <= mul_b;
        cap_m   <= mul_mod;
        mres    <= W'(({{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b}) % {{W{1'b0}}, mul_mod});
      end
    end
  end

  // Stray completion pulses only when no request is outstanding and the job is busy.
  always @(negedge clk) begin
    stray <= stray_en && busy && !mul_start && !pending && !md_q && ($urandom_range(0, 1) == 1);
    junk  <= {$urandom, $urandom, $urandom, $urandom};
  end

  assign mul_done   = md_q | stray;
  assign mul_result = md_q ? mres : junk;

  always @(negedge clk) begin
    if (!rst && (pending || md_q)) begin
      if (mul_start || mul_a !== cap_a || mul_b !== cap_b || mul_mod !== cap_m)
        hs_bad <= hs_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] ref_exp(input logic [W-1:0] b, input logic [W-1:0] e,
                                           input logic [W-1:0] m);
    logic [2*W-1:0] r, x, mm;
    if (m < 2) return '0;
    mm = {{W{1'b0}}, m};
    r  = 1;
    x  = {{W{1'b0}}, b} % mm;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[W-1:0];
  endfunction

  function automatic int ref_nmul(input logic [W-1:0] e);
    int msb = -1;
    if (e == '0) return 0;
    for (int i = 0; i < W; i++) if (e[i]) msb = i;
    return $countones(e) + msb;
  endfunction

  // Cycle 1 is the cycle in which start is presented; cyc is the cycle of the first done.
  task automatic run_job(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                         input int hold, output logic [W-1:0] res, output logic err,
                         output int cyc, output int nmul, output int ndone);
    bit got = 0;
    bit to  = 1;
    int post = 0;
    nmul = 0; ndone = 0; cyc = 0; res = '0; err = 1'b0;
    @(negedge clk);
    base = b; exp = e; mod = m; start = 1'b1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      if (k >= hold) start = 1'b0;
      if (k == 1) begin
        base = {$urandom, $urandom, $urandom, $urandom};
        exp  = {$urandom, $urandom, $urandom, $urandom};
        mod  = {$urandom, $urandom, $urandom, $urandom};
      end
      if (mul_start) nmul++;
      if (done) begin
        ndone++;
        if (!got) begin
          got = 1; cyc = k + 1; res = result; err = error;
        end
      end
      if (got) post++;
      if (got && k >= hold && post >= 3) begin
        to = 0;
        break;
      end
    end
    start = 1'b0;
    chk("job_timeout", W'(to), '0);
  endtask

  logic [W-1:0] r, b, e, m;
  logic         er;
  int           cyc, nm, nd, seen;

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; exp = '0; mod = '0; stray_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_error", W'(error), '0);
    chk("rst_result", result, '0);
    chk("rst_mul_start", W'(mul_start), '0);
    chk("rst_mul_a", mul_a, '0);
    chk("rst_mul_b", mul_b, '0);
    chk("rst_mul_mod", mul_mod, '0);
    rst = 1'b0;

    run_job(W'(4), W'(13), W'(497), 1, r, er, cyc, nm, nd);
    chk("t1_result", r, W'(445));
    chk("t1_error", W'(er), '0);
    chk("t1_nmul", W'(nm), W'(6));
    chk("t1_ndone", W'(nd), W'(1));

    run_job(W'(7), W'(0), W'(11), 1, r, er, cyc, nm, nd);
    chk("t2_result", r, W'(1));
    chk("t2_cycles", W'(cyc), W'(3));
    chk("t2_nmul", W'(nm), '0);

    for (int i = 0; i < 2; i++) begin
      run_job(W'($urandom), W'($urandom), W'(1 - i), 1, r, er, cyc, nm, nd);
      chk("t3_error", W'(er), W'(1));
      chk("t3_result", r, '0);
      chk("t3_nmul", W'(nm), '0);
      chk("t3_ndone", W'(nd), W'(1));
      chk("t3_cycles", W'(cyc), W'(3));
    end
    run_job(W'(5), W'(3), W'(13), 1, r, er, cyc, nm, nd);
    chk("t3_error_cleared", W'(er), '0);
    chk("t3_after_result", r, W'(8));

    // Reset while the first square is outstanding.
    @(negedge clk);
    base = W'(3); exp = W'(16'hFFFF); mod = W'(1000003); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < LIMIT && seen < 2; k++) begin
      if (mul_start) seen++;
      if (seen < 2) @(negedge clk);
    end
    chk("t4_reach_sqr", W'(seen), W'(2));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_busy", W'(busy), '0);
    chk("t4_done", W'(done), '0);
    chk("t4_error", W'(error), '0);
    chk("t4_result", result, '0);
    chk("t4_mul_start", W'(mul_start), '0);
    chk("t4_mul_ops", mul_a | mul_b | mul_mod, '0);
    rst = 1'b0;
    run_job(W'(2), W'(10), W'(1000), 1, r, er, cyc, nm, nd);
    chk("t4_fresh_result", r, W'(24));

    stray_en = 1'b1;
    m = {$urandom, $urandom, $urandom, $urandom} | W'(3);
    b = {$urandom, $urandom, $urandom, $urandom} % m;
    run_job(b, W'(16'hFFFF), m, 50, r, er, cyc, nm, nd);
    chk("t5_ndone", W'(nd), W'(1));
    chk("t5_result", r, ref_exp(b, W'(16'hFFFF), m));
    chk("t5_nmul", W'(nm), W'(ref_nmul(W'(16'hFFFF))));
    stray_en = 1'b0;

    m = {1'b0, {(W-1){1'b1}}};
    run_job(W'(2), W'(127), m, 1, r, er, cyc, nm, nd);
    chk("t6_result", r, W'(1));
    chk("t6_nmul", W'(nm), W'(13));

    for (int i = 0; i < 8; i++) begin
      m = {$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 120);
      if (m < 2) m = W'(2 + $urandom_range(0, 100));
      b = {$urandom, $urandom, $urandom, $urandom} % m;
      e = (i == 7) ? {$urandom, $urandom, $urandom, $urandom} : W'($urandom_range(0, 32'hFFFFFF));
      stray_en = i[0];
      run_job(b, e, m, 1 + i, r, er, cyc, nm, nd);
      chk("rnd_result", r, ref_exp(b, e, m));
      chk("rnd_nmul", W'(nm), W'(ref_nmul(e)));
      chk("rnd_error", W'(er), '0);
    end
    stray_en = 1'b0;

    chk("handshake", W'(hs_bad), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
